// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encodings and clog2.
package fifo_wr_arbiter_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  // Ceiling log2, same definition as the FIFO uses for its pointer widths.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((r < 32) && ((64'd1 << r) < 64'(n))) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first requesting index strictly after last, wrapping at NUM_REQ.
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [clog2(NUM_REQ)-1:0] last,
  output logic [clog2(NUM_REQ)-1:0] pick,
  output logic                      valid
);

  localparam int unsigned LW = clog2(NUM_REQ);

  // Scan from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    int idx;
    pick  = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (req[idx]) begin
        pick  = LW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters,
// granting one owner at a time for bursts of up to MAX_BURST writes.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  output logic                          busy
);

  localparam int unsigned LW = clog2(NUM_REQ);
  localparam int unsigned BW = clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);

  logic          state;
  logic          state_next;
  logic [LW-1:0] last;
  logic [BW-1:0] beat;
  logic [LW-1:0] pick;
  logic          pick_valid;
  logic          owner_req;
  logic          write_ok;
  logic          start;
  logic          finish;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req   (req),
    .last  (last),
    .pick  (pick),
    .valid (pick_valid)
  );

  // While in BURST, last always holds the owner index.
  assign owner_req = req[last];
  assign write_ok  = (state == ST_BURST) & owner_req & ~fifo_full;
  assign start     = (state == ST_IDLE) & pick_valid & ~fifo_full;
  assign finish    = (state == ST_BURST) &
                     (~owner_req | (write_ok & (beat == BEAT_LAST)));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == ST_IDLE) begin
      if (start) state_next = ST_BURST;
    end else begin
      if (finish) state_next = ST_IDLE;
    end
  end

  // Write strobe is suppressed in the reset cycle so an abandoned burst issues nothing.
  always_comb begin
    fifo_wr_en   = 1'b0;
    ack          = '0;
    fifo_wr_data = '0;
    if ((state == ST_BURST) && !reset) begin
      fifo_wr_en   = write_ok;
      ack[last]    = write_ok;
      fifo_wr_data = req_data[int'(last) * DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant <= '0;
      beat  <= '0;
      last  <= LW'(NUM_REQ - 1);
    end else if (start) begin
      grant <= NUM_REQ'(1) << pick;
      beat  <= '0;
      last  <= pick;
    end else if (finish) begin
      grant <= '0;
      beat  <= '0;
    end else if (write_ok) begin
      beat  <= beat + BW'(1);
    end
  end

  assign busy = (state == ST_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a 4-requester instance plus a 3-requester wrap check.
module tb_fifo_wr_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned MB = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req, grant, ack;
  logic [NR*DW-1:0]  req_data;
  logic [DW-1:0]     wr_data;
  logic              wr_en, full, busy;

  logic [2:0]        req3, grant3, ack3;
  logic [3*DW-1:0]   req_data3;
  logic [DW-1:0]     wr_data3;
  logic              wr_en3, full3, busy3;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] wlog[$];

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant),
    .ack(ack), .fifo_wr_data(wr_data), .fifo_wr_en(wr_en), .fifo_full(full),
    .busy(busy)
  );

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(3), .MAX_BURST(2)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .req_data(req_data3), .grant(grant3),
    .ack(ack3), .fifo_wr_data(wr_data3), .fifo_wr_en(wr_en3), .fifo_full(full3),
    .busy(busy3)
  );

  always #5 clk = ~clk;

  // FIFO model: capture accepted words mid-cycle, where inputs and outputs are stable.
  always @(negedge clk) if (wr_en === 1'b1) wlog.push_back(wr_data);

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    full      = 1'b0;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req3      = '0;
    full3     = 1'b0;
    req_data3 = {8'hC2, 8'hC1, 8'hC0};
    cyc();
    cyc();

    // Reset state
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_data", 32'(wr_data), 32'h0);
    chk("rst_last", 32'(dut.last), 32'h3);
    chk("rst_grant3", 32'(grant3), 32'h0);
    reset = 1'b0;
    cyc();

    // Single requester: grant next cycle, 4 writes, one idle cycle, re-grant
    req = 4'b0001;
    settle();
    chk("idle_no_wr", 32'(wr_en), 32'h0);
    cyc();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    for (int k = 0; k < 4; k++) begin
      chk("t1_wr_en", 32'(wr_en), 32'h1);
      chk("t1_data", 32'(wr_data), 32'hA0);
      chk("t1_ack", 32'(ack), 32'h1);
      cyc();
    end
    chk("t1_gap_grant", 32'(grant), 32'h0);
    chk("t1_gap_wr_en", 32'(wr_en), 32'h0);
    chk("t1_gap_busy", 32'(busy), 32'h0);
    cyc();
    chk("t1_regrant", 32'(grant), 32'h1);
    req = 4'b0000;
    settle();
    chk("t1_drop_wr_en", 32'(wr_en), 32'h0);
    cyc();
    chk("t1_drop_exit", 32'(grant), 32'h0);
    chk("t1_log_size", 32'(wlog.size()), 32'd4);

    // All requesters saturated: round-robin order over five bursts
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    req   = 4'b1111;
    wlog.delete();
    cyc();
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) begin
        chk("t2_grant", 32'(grant), 32'h1 << (b % 4));
        chk("t2_wr_en", 32'(wr_en), 32'h1);
        cyc();
      end
      chk("t2_gap", 32'(grant), 32'h0);
      cyc();
    end
    chk("t2_log_size", 32'(wlog.size()), 32'd20);
    for (int i = 0; i < 20 && i < wlog.size(); i++)
      chk("t2_fifo_order", 32'(wlog[i]), 32'hA0 + 32'((i / 4) % 4));
    req = 4'b0000;
    cyc();

    // Owner 2 stalls on full for 3 cycles after its 2nd beat
    req = 4'b0100;
    cyc();
    chk("t3_grant", 32'(grant), 32'h4);
    chk("t3_beat1", 32'(wr_en), 32'h1);
    cyc();
    chk("t3_beat2", 32'(wr_en), 32'h1);
    cyc();
    full = 1'b1;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_wr_en", 32'(wr_en), 32'h0);
      chk("t3_stall_grant", 32'(grant), 32'h4);
      chk("t3_stall_ack", 32'(ack), 32'h0);
      cyc();
    end
    full = 1'b0;
    settle();
    chk("t3_beat3", 32'(wr_en), 32'h1);
    chk("t3_beat3_ack", 32'(ack), 32'h4);
    chk("t3_beat3_data", 32'(wr_data), 32'hA2);
    cyc();
    chk("t3_beat4", 32'(wr_en), 32'h1);
    cyc();
    chk("t3_exit", 32'(grant), 32'h0);
    req = 4'b0000;
    cyc();

    // Owner 1 drops req after one write; others ignored until IDLE
    req = 4'b0010;
    cyc();
    chk("t4_grant", 32'(grant), 32'h2);
    chk("t4_write", 32'(wr_en), 32'h1);
    cyc();
    req = 4'b1001;
    settle();
    chk("t4_drop_wr_en", 32'(wr_en), 32'h0);
    chk("t4_drop_ack", 32'(ack), 32'h0);
    chk("t4_drop_grant", 32'(grant), 32'h2);
    cyc();
    chk("t4_exit", 32'(grant), 32'h0);
    chk("t4_last", 32'(dut.last), 32'h1);
    cyc();
    chk("t4_next_grant", 32'(grant), 32'h8);
    req = 4'b0000;
    cyc();

    // Full blocks a pick in IDLE; owner drop coincident with full exits
    req  = 4'b0001;
    full = 1'b1;
    cyc();
    chk("t5_full_idle", 32'(grant), 32'h0);
    full = 1'b0;
    cyc();
    chk("t5_grant", 32'(grant), 32'h1);
    req  = 4'b0000;
    full = 1'b1;
    settle();
    chk("t5_dropfull_wr_en", 32'(wr_en), 32'h0);
    cyc();
    chk("t5_dropfull_exit", 32'(grant), 32'h0);
    chk("t5_dropfull_busy", 32'(busy), 32'h0);
    full = 1'b0;

    // Reset mid-burst at beat 2
    req = 4'b0100;
    cyc();
    chk("t6_grant", 32'(grant), 32'h4);
    cyc();
    cyc();
    reset = 1'b1;
    settle();
    chk("t6_rst_wr_en", 32'(wr_en), 32'h0);
    chk("t6_rst_ack", 32'(ack), 32'h0);
    cyc();
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_last", 32'(dut.last), 32'h3);
    chk("t6_rst_data", 32'(wr_data), 32'h0);
    reset = 1'b0;
    req   = 4'b0110;
    cyc();
    chk("t6_first_grant", 32'(grant), 32'h2);
    req = 4'b0000;
    cyc();

    // NUM_REQ=3, req=101, last=2 after reset: grant 0, then 2, then wrap to 0
    req3 = 3'b101;
    cyc();
    chk("t7_grant0", 32'(grant3), 32'h1);
    chk("t7_data0", 32'(wr_data3), 32'hC0);
    chk("t7_wr0", 32'(wr_en3), 32'h1);
    cyc();
    chk("t7_wr1", 32'(wr_en3), 32'h1);
    cyc();
    chk("t7_gap0", 32'(grant3), 32'h0);
    cyc();
    chk("t7_grant2", 32'(grant3), 32'h4);
    chk("t7_data2", 32'(wr_data3), 32'hC2);
    chk("t7_last2", 32'(dut3.last), 32'h2);
    cyc();
    cyc();
    chk("t7_gap1", 32'(grant3), 32'h0);
    cyc();
    chk("t7_wrap_grant", 32'(grant3), 32'h1);
    req3 = 3'b000;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
